// File: rtl/multicycle_ctrl_if.sv
// Control/memory bus of the multi-cycle CPU controller.
// Groups the instruction/status inputs, the memory handshake and every
// datapath enable/mux select driven by the controller.
//   master : the controller (multicycle_ctrl)
//   slave  : the datapath / memory side that consumes the controls
interface multicycle_ctrl_if;
    logic [15:0] instr;        // IR: [15:13] opcode, [12:10] rs, [9:7] rt, [6:4] rd, [3:0] func
    logic        alu_zero;     // ALU zero flag, meaningful in EXEC
    logic        mem_ack;      // one-cycle memory completion pulse
    logic        mem_req;      // memory request, held until ack or timeout
    logic        mem_we;       // 1 = store
    logic        mem_addr_sel; // 0 = PC, 1 = ALU result
    logic        ir_we;        // load IR from memory read data
    logic        mdr_we;       // load memory data register
    logic        pc_we;        // PC write enable
    logic [1:0]  pc_src;       // 00 = PC+1, 01 = branch target, 10 = jump target
    logic [2:0]  alu_code;     // ALU operation
    logic        alu_src_b;    // 0 = rt, 1 = sign-extended immediate
    logic        reg_we;       // register file write enable
    logic        reg_dst;      // 0 = rt, 1 = rd
    logic        wb_sel;       // 0 = ALU output register, 1 = MDR
    logic        illegal;      // pulse on undefined R-type func
    logic        mem_err;      // pulse on memory timeout
    logic [2:0]  state;        // current state, debug only

    modport master (
        input  instr, alu_zero, mem_ack,
        output mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src,
               alu_code, alu_src_b, reg_we, reg_dst, wb_sel, illegal, mem_err, state
    );

    modport slave (
        output instr, alu_zero, mem_ack,
        input  mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src,
               alu_code, alu_src_b, reg_we, reg_dst, wb_sel, illegal, mem_err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB), decodes opcode/func
// into the ALU code, and runs the memory handshake with a timeout watchdog.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high; forces every output to 0
//   bus  : multicycle_ctrl_if.master (instr/status in, datapath controls out)
// The state register and the timeout counter are the only flops; all
// outputs are decoded combinationally (Moore-style with ack/zero qualifiers).
module multicycle_ctrl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int CW          = 8
) (
    input logic             clk,
    input logic             rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t          state_q, state_next;
    logic [CW-1:0]   cnt_q, cnt_next;
    logic [2:0]      opcode;
    logic [3:0]      func;
    logic            waiting;
    logic            timeout;

    logic            mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0]      pc_src;
    logic [2:0]      alu_code;
    logic            alu_src_b, reg_we, reg_dst, wb_sel, illegal, mem_err;

    // Undefined R-type func codes: 0010 and 1000..1111.
    function automatic logic func_illegal(input logic [3:0] f);
        return (f == 4'b0010) || f[3];
    endfunction

    // ALU code for the current instruction; R-type func maps straight
    // through for the legal codes, jmp has no ALU use and drives 000.
    function automatic logic [2:0] alu_decode(input logic [2:0] op, input logic [3:0] f);
        case (op)
            OP_R:    return func_illegal(f) ? 3'b000 : f[2:0];
            3'b001:  return 3'b000;
            3'b010:  return 3'b001;
            3'b011:  return 3'b011;
            OP_BEQ:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign opcode  = bus.instr[15:13];
    assign func    = bus.instr[3:0];
    assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !bus.mem_ack;
    // Fires on the ACK_TIMEOUT-th waiting cycle; an ack in that cycle wins.
    assign timeout = waiting && (cnt_q == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        alu_code     = 3'b000;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 1'b0;
        wb_sel       = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;  // retry: stay in FETCH, counter clears
                end
            end
            DECODE: begin
                if (opcode == OP_JMP) begin
                    pc_we      = 1'b1;
                    pc_src     = 2'b10;
                    state_next = FETCH;
                end else if (opcode == OP_R && func_illegal(func)) begin
                    illegal    = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_code  = alu_decode(opcode, func);
                alu_src_b = (opcode >= 3'b001) && (opcode <= 3'b101);
                if (opcode == OP_BEQ) begin
                    if (bus.alu_zero) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b01;
                    end
                    state_next = FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_SW);
                if (bus.mem_ack) begin
                    mdr_we     = (opcode == OP_LW);
                    state_next = (opcode == OP_LW) ? WB : FETCH;
                end else if (timeout) begin
                    mem_err    = 1'b1;  // abort the instruction, no write-back
                    state_next = FETCH;
                end
            end
            WB: begin
                reg_we     = 1'b1;
                reg_dst    = (opcode == OP_R);
                wb_sel     = (opcode == OP_LW);
                alu_code   = alu_decode(opcode, func);
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Reset masks everything, dropping an outstanding request at once.
        if (rst) begin
            state_next   = FETCH;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 2'b00;
            alu_code     = 3'b000;
            alu_src_b    = 1'b0;
            reg_we       = 1'b0;
            reg_dst      = 1'b0;
            wb_sel       = 1'b0;
            illegal      = 1'b0;
            mem_err      = 1'b0;
        end
    end

    // Counter restarts on every state change and after each timeout.
    always_comb begin
        cnt_next = '0;
        if (!rst && !timeout && state_next == state_q && waiting)
            cnt_next = cnt_q + CW'(1);
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_we        = ir_we;
    assign bus.mdr_we       = mdr_we;
    assign bus.pc_we        = pc_we;
    assign bus.pc_src       = pc_src;
    assign bus.alu_code     = alu_code;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.reg_we       = reg_we;
    assign bus.reg_dst      = reg_dst;
    assign bus.wb_sel       = wb_sel;
    assign bus.illegal      = illegal;
    assign bus.mem_err      = mem_err;
    assign bus.state        = rst ? 3'd0 : state_q;
endmodule
